// File: rtl/serial_sub.sv
// serial_sub: bit-serial W-bit subtractor, d = a - b - bi, LSB first.
// One full-subtractor cell, a borrow flop and operand/result shift registers.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_sub #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bi,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bo
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   sa, sa_nxt;
    logic [W-1:0]   sb, sb_nxt;
    logic [W-1:0]   res, res_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           br, br_nxt;
    logic           busy_nxt, done_nxt, bo_nxt;
    logic [W-1:0]   d_nxt;
`ifdef SERIAL_SUB_OVF_EN
    logic           ovf_nxt;
`endif

    // Full-subtractor cell on the current LSBs of the operand shift registers
    logic           ak_c, bk_c, diff_c, borrow_c;
    logic [W-1:0]   res_shift_c;

    assign ak_c     = sa[0];
    assign bk_c     = sb[0];
    assign diff_c   = ak_c ^ bk_c ^ br;
    assign borrow_c = (~ak_c & bk_c) | (~(ak_c ^ bk_c) & br);

    // New difference bit enters at the MSB so the word ends LSB-aligned
    generate
        if (W == 1) begin : g_w1
            assign res_shift_c = diff_c;
        end else begin : g_wn
            assign res_shift_c = {diff_c, res[W-1:1]};
        end
    endgenerate

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bo    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            sa    <= sa_nxt;
            sb    <= sb_nxt;
            res   <= res_nxt;
            cnt   <= cnt_nxt;
            br    <= br_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            d     <= d_nxt;
            bo    <= bo_nxt;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= ovf_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        sa_nxt    = sa;
        sb_nxt    = sb;
        res_nxt   = res;
        cnt_nxt   = cnt;
        br_nxt    = br;
        done_nxt  = 1'b0;
        d_nxt     = d;
        bo_nxt    = bo;
`ifdef SERIAL_SUB_OVF_EN
        ovf_nxt   = ovf;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    sa_nxt    = a;
                    sb_nxt    = b;
                    br_nxt    = bi;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sa_nxt  = sa >> 1;
                sb_nxt  = sb >> 1;
                br_nxt  = borrow_c;
                res_nxt = res_shift_c;
                cnt_nxt = cnt + CW'(1);
                if (cnt == LAST) begin
                    d_nxt     = res_shift_c;
                    bo_nxt    = borrow_c;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow into the sign bit differs from borrow out of it
                    ovf_nxt   = br ^ borrow_c;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == SHIFT);
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at W=4 and W=1.
// ovf is checked only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

    typedef struct packed {
        logic [3:0] d;
        logic       bo;
        logic       ovf;
    } exp4_t;

    typedef struct packed {
        logic d;
        logic bo;
        logic ovf;
    } exp1_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, bi4, busy4, done4, bo4;
    logic [3:0] a4, b4, d4;
    logic       start1, bi1, busy1, done1, bo1;
    logic [0:0] a1, b1, d1;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf4, ovf1;
`endif

    exp4_t q4[$];
    exp1_t q1[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    serial_sub #(.W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bi(bi4),
        .busy(busy4), .done(done4), .d(d4), .bo(bo4)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    serial_sub #(.W(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bi(bi1),
        .busy(busy1), .done(done1), .d(d1), .bo(bo1)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    // Reference model: wide unsigned subtraction plus signed range check
    function automatic exp4_t model4(input logic [3:0] ia, input logic [3:0] ib, input logic ibi);
        exp4_t      e;
        logic [4:0] f;
        int         s;
        f     = {1'b0, ia} - {1'b0, ib} - 5'(ibi);
        s     = int'($signed(ia)) - int'($signed(ib)) - (ibi ? 1 : 0);
        e.d   = f[3:0];
        e.bo  = f[4];
`ifdef SERIAL_SUB_OVF_EN
        e.ovf = (s < -8) || (s > 7);
`else
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp1_t model1(input logic ia, input logic ib, input logic ibi);
        exp1_t      e;
        logic [1:0] f;
        int         s;
        f     = {1'b0, ia} - {1'b0, ib} - 2'(ibi);
        s     = (ia ? -1 : 0) - (ib ? -1 : 0) - (ibi ? 1 : 0);
        e.d   = f[0];
        e.bo  = f[1];
`ifdef SERIAL_SUB_OVF_EN
        e.ovf = (s < -1) || (s > 0);
`else
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp4_t obs4();
        exp4_t o;
        o.d   = d4;
        o.bo  = bo4;
`ifdef SERIAL_SUB_OVF_EN
        o.ovf = ovf4;
`else
        o.ovf = 1'b0;
`endif
        return o;
    endfunction

    function automatic exp1_t obs1();
        exp1_t o;
        o.d   = d1[0];
        o.bo  = bo1;
`ifdef SERIAL_SUB_OVF_EN
        o.ovf = ovf1;
`else
        o.ovf = 1'b0;
`endif
        return o;
    endfunction

    // Drive one request on the W=4 instance and record its expected result
    task automatic issue4(input logic [3:0] ia, input logic [3:0] ib, input logic ibi);
        @(negedge clk);
        a4 = ia; b4 = ib; bi4 = ibi; start4 = 1'b1;
        q4.push_back(model4(ia, ib, ibi));
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic issue1(input logic ia, input logic ib, input logic ibi);
        @(negedge clk);
        a1 = ia; b1 = ib; bi1 = ibi; start1 = 1'b1;
        q1.push_back(model1(ia, ib, ibi));
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    // Wait (bounded) for done; lat = edges after the call, 0 on timeout
    task automatic collect4(output exp4_t o, output int lat);
        o = '0; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                o = obs4(); lat = i;
                break;
            end
        end
    endtask

    task automatic collect1(output exp1_t o, output int lat);
        o = '0; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done1) begin
                o = obs1(); lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bi1 = 1'b0;
        #3;
        total++;
        if ({busy4, done4, d4, bo4, busy1, done1, d1, bo1} !== 10'b0) begin
            bad++;
            $display("FAIL reset: got busy4=%b done4=%b d4=%b bo4=%b busy1=%b done1=%b d1=%b bo1=%b want all 0",
                     busy4, done4, d4, bo4, busy1, done1, d1, bo1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [8:0] vec [6];
        exp4_t      o, e;
        int         lat;
        vec[0] = {4'b0001, 4'b1010, 1'b0};
        vec[1] = {4'b1100, 4'b0011, 1'b1};
        vec[2] = {4'b0101, 4'b0101, 1'b0};
        vec[3] = {4'b0101, 4'b0101, 1'b1};
        vec[4] = {4'b0111, 4'b1000, 1'b0};
        vec[5] = {4'b0111, 4'b1111, 1'b1};
        for (int i = 0; i < 6; i++) begin
            issue4(vec[i][8:5], vec[i][4:1], vec[i][0]);
            total++;
            if (busy4 !== 1'b1) begin
                bad++;
                $display("FAIL basic_busy[%0d]: got %b want 1", i, busy4);
            end
            collect4(o, lat);
            e = q4.pop_front();
            total++;
            if (lat !== 4) begin
                bad++;
                $display("FAIL basic_latency[%0d]: got %0d want 4", i, lat);
            end
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL basic_result[%0d]: got d=%b bo=%b ovf=%b want d=%b bo=%b ovf=%b",
                         i, o.d, o.bo, o.ovf, e.d, e.bo, e.ovf);
            end
            @(posedge clk); #1;
            total++;
            if (done4 !== 1'b0 || busy4 !== 1'b0 || obs4() !== e) begin
                bad++;
                $display("FAIL basic_hold[%0d]: got done=%b busy=%b d=%b want done=0 busy=0 d=%b",
                         i, done4, busy4, d4, e.d);
            end
        end
    endtask

    task automatic test_back_to_back();
        int    accepts = 0, dones = 0, last_acc = -1;
        logic  prev_busy;
        exp4_t e;
        @(negedge clk);
        a4 = 4'b1001; b4 = 4'b0011; bi4 = 1'b0; start4 = 1'b1;
        prev_busy = busy4;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy4 && !prev_busy) begin
                if (last_acc >= 0) begin
                    total++;
                    if (i - last_acc !== 5) begin
                        bad++;
                        $display("FAIL b2b_spacing: got %0d want 5", i - last_acc);
                    end
                end
                last_acc = i;
                accepts++;
                q4.push_back(model4(a4, b4, bi4));
            end
            if (done4) begin
                dones++;
                e = (q4.size() > 0) ? q4.pop_front() : exp4_t'('1);
                total++;
                if (obs4() !== e) begin
                    bad++;
                    $display("FAIL b2b_result: got d=%b bo=%b want d=%b bo=%b", d4, bo4, e.d, e.bo);
                end
            end
            prev_busy = busy4;
        end
        @(negedge clk);
        start4 = 1'b0;
        total++;
        if (accepts !== 4 || dones !== 4) begin
            bad++;
            $display("FAIL b2b_count: got accepts=%0d dones=%0d want 4 4", accepts, dones);
        end
    endtask

    task automatic test_midchange();
        exp4_t o, e;
        int    lat;
        issue4(4'b1010, 4'b0110, 1'b0);
        @(posedge clk); #1;
        a4 = 4'b1111; b4 = 4'b0000; bi4 = 1'b1; start4 = 1'b0;
        collect4(o, lat);
        e = q4.pop_front();
        total++;
        if (lat == 0 || o !== e) begin
            bad++;
            $display("FAIL midchange: got d=%b bo=%b lat=%0d want d=%b bo=%b", o.d, o.bo, lat, e.d, e.bo);
        end
    endtask

    task automatic test_reset_mid();
        int    spurious = 0;
        exp4_t o, e;
        int    lat;
        issue4(4'b0011, 4'b0001, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        q4.delete();
        total++;
        if ({busy4, done4, d4, bo4} !== 7'b0) begin
            bad++;
            $display("FAIL reset_mid: got busy=%b done=%b d=%b bo=%b want all 0", busy4, done4, d4, bo4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done4) spurious++;
        end
        total++;
        if (spurious !== 0) begin
            bad++;
            $display("FAIL reset_nodone: got %0d done pulses want 0", spurious);
        end
        issue4(4'b1000, 4'b0001, 1'b1);
        collect4(o, lat);
        e = q4.pop_front();
        total++;
        if (lat !== 4 || o !== e) begin
            bad++;
            $display("FAIL reset_recover: got d=%b bo=%b lat=%0d want d=%b bo=%b lat=4", o.d, o.bo, lat, e.d, e.bo);
        end
    endtask

    task automatic test_w1();
        exp1_t o, e;
        int    lat;
        issue1(1'b0, 1'b1, 1'b0);
        collect1(o, lat);
        e = q1.pop_front();
        total++;
        if (lat !== 1 || o.d !== 1'b1 || o.bo !== 1'b1) begin
            bad++;
            $display("FAIL w1_first: got d=%b bo=%b lat=%0d want d=1 bo=1 lat=1", o.d, o.bo, lat);
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            issue1(v[2], v[1], v[0]);
            collect1(o, lat);
            e = q1.pop_front();
            total++;
            if (lat !== 1 || o !== e) begin
                bad++;
                $display("FAIL w1_sweep[%0d]: got d=%b bo=%b ovf=%b lat=%0d want d=%b bo=%b ovf=%b lat=1",
                         i, o.d, o.bo, o.ovf, lat, e.d, e.bo, e.ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_midchange();
        test_reset_mid();
        test_w1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial W-bit subtractor with borrow-in/borrow-out, the inverse-direction companion of the team's 4-bit ripple adder. It computes d = a − b − bi one bit per clock, LSB first, using a single full-subtractor cell, a borrow flop and shift registers. A start/busy/done handshake lets a sequencing block or a bench issue operations and collect results. It serves area-constrained datapaths and the adder/subtractor cross-check bench.

## Interface
- W, default 4: operand/result width, ≥ 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy = 0.
- a  in  W  minuend, captured on the accepting edge.
- b  in  W  subtrahend, captured on the accepting edge.
- bi  in  1  borrow-in, captured on the accepting edge.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when d/bo are valid.
- d  out  W  difference (a − b − bi) mod 2^W.
- bo  out  1  borrow-out: 1 iff a < b + bi (unsigned).
- ovf  out  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- States: IDLE, SHIFT.
- IDLE: busy = 0. On an edge with start = 1, latch a, b and bi into the shift registers and borrow flop, clear the bit counter, and go to SHIFT.
- SHIFT: busy = 1. Each edge processes bit k = counter:
  - diff_k = a_k ^ b_k ^ br
  - br ← (~a_k & b_k) | (~(a_k ^ b_k) & br)
  - diff_k is shifted into the result register MSB-first so that it ends LSB-aligned.
  - Counter increments each edge.
- On the edge processing bit W−1:
  - d ← full result, bo ← final borrow, done ← 1.
  - State returns to IDLE.
- d and bo hold their values until the next completion. They are not cleared at start.
- start while busy = 1 is ignored, with no queueing. a, b and bi may change freely after acceptance.
- Counter width is clog2(W), minimum 1. W = 1 completes in a single SHIFT cycle.
- Reset (asserted at any time, including mid-operation): state IDLE, busy = 0, done = 0, d = 0, bo = 0, ovf = 0, counter and shift registers 0. A partial operation is discarded and no done is issued.

## Timing
- Accepting edge T0: busy is high after T0.
- Bits 0..W−1 are processed on edges T1..TW.
- After TW: done = 1 and d/bo are valid for exactly one cycle. busy = 0.
- Latency: W cycles from accept to done. Throughput: one operation per W+1 cycles.
- A start held high at TW is not accepted, because busy was 1 before that edge. Earliest next accept is T(W+1).
- done is a registered pulse and deasserts on the following edge unconditionally.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - ovf port and logic are present.
  - ovf = (borrow into bit W−1) XOR (borrow out of bit W−1), i.e. two's-complement a − b − bi is outside [−2^(W−1), 2^(W−1)−1].
  - ovf updates with d/bo at done and resets to 0.
- Not defined: ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- W = 4, a = 0001, b = 1010, bi = 0 → done 4 cycles after accept, d = 0111, bo = 1, ovf = 0.
- a = 1100, b = 0011, bi = 1 → d = 1000, bo = 0. Then a = 0101, b = 0101, bi = 0 → d = 0000, bo = 0. Then the same operands with bi = 1 → d = 1111, bo = 1.
- With the macro: a = 0111, b = 1000, bi = 0 → d = 1111, bo = 1, ovf = 1. a = 0111, b = 1111, bi = 1 → d = 0111, bo = 1, ovf = 0.
- Hold start high continuously with fixed operands → accepts spaced exactly 5 cycles apart, one done per operation. Change a/b mid-SHIFT → result reflects the captured operands.
- Assert rst_n low at cycle 2 of SHIFT → busy, done, d and bo go 0 immediately, and no done follows. A new start after release completes normally.
- W = 1 instance: a = 0, b = 1, bi = 0 → done 1 cycle after accept, d = 1, bo = 1. Also sweep all 8 input combinations for W = 1.
